pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage RV32IM pipeline. Detects load-use hazards that the operand-forwarding network cannot cover, holds the pipeline while the multi-cycle M-extension unit occupies EX, squashes wrong-path instructions on taken branches, and freezes or bubbles stages on instruction/data memory busywait. Drives the stall and flush enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- MULDIV_CYCLES, 4, total cycles a MUL/DIV instruction occupies EX (>= 1); internal counter width is $clog2(MULDIV_CYCLES)+1
- CLK  input  1  pipeline clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- ID_ADDR1, ID_ADDR2  input  5  rs1/rs2 of instruction in ID
- ID_USE1, ID_USE2  input  1  ID instruction actually reads rs1/rs2
- EXE_ADDR  input  5  rd of instruction in EX
- EXE_MEMREAD  input  1  instruction in EX is a load
- EXE_MULDIV  input  1  instruction in EX is an M-extension op
- BRANCH_TAKEN  input  1  EX resolved a taken branch/jump
- IMEM_BUSYWAIT, DMEM_BUSYWAIT  input  1  memory not ready this cycle
- PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, MEMWB_STALL  output  1  hold register contents
- IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH  output  1  load NOP bubble into register
- MULDIV_DONE  output  1  one-cycle pulse: MUL/DIV result valid in EX this cycle

## Operation
- Clock is CLK; reset is synchronous and active-high on RESET.
- FSM states: RUN, LOAD_STALL, MULDIV_BUSY. Counter CNT.
- Load-use hit = EXE_MEMREAD & EXE_ADDR!=0 & ((ID_USE1 & ID_ADDR1==EXE_ADDR) | (ID_USE2 & ID_ADDR2==EXE_ADDR)).
- Outputs are combinational from state, CNT and inputs; evaluated in strict priority:
  1. DMEM_BUSYWAIT: all five *_STALL = 1, all flushes 0; state and CNT held.
  2. MULDIV: (RUN & EXE_MULDIV & MULDIV_CYCLES>1) or (MULDIV_BUSY & CNT!=0): PC/IFID/IDEX_STALL=1, EXMEM_FLUSH=1. MULDIV_BUSY & CNT==0: no stalls, MULDIV_DONE=1.
  3. BRANCH_TAKEN (RUN/LOAD_STALL only): IFID_FLUSH=1, IDEX_FLUSH=1, PC not stalled (target loads).
  4. Load-use hit in RUN: PC_STALL=1, IFID_STALL=1, IDEX_FLUSH=1.
  5. IMEM_BUSYWAIT: PC_STALL=1, IFID_FLUSH=1.
  6. Otherwise all outputs 0.
- Transitions (only when DMEM_BUSYWAIT=0):
  - RUN -> MULDIV_BUSY on EXE_MULDIV & MULDIV_CYCLES>1, CNT <= MULDIV_CYCLES-2. MULDIV_CYCLES==1: MULDIV_DONE=1 in RUN, no stall.
  - RUN -> LOAD_STALL on load-use hit without branch.
  - LOAD_STALL -> RUN unconditionally; no hazard re-detection in LOAD_STALL.
  - MULDIV_BUSY: CNT!=0 -> CNT-1; CNT==0 -> RUN.
- EXE_MULDIV and BRANCH_TAKEN together: MULDIV wins, branch ignored (illegal combination).

## Timing
- RESET high: state RUN, CNT 0, every output forced 0 in that cycle.
- Load-use: exactly 1 stall cycle, 1 bubble in ID/EX; zero latency (same-cycle combinational).
- MUL/DIV: MULDIV_CYCLES cycles in EX total, MULDIV_CYCLES-1 stall cycles, MULDIV_DONE on the last.
- Branch: 2 bubbles (IF/ID, ID/EX) in the resolve cycle.
- DMEM_BUSYWAIT mid-MULDIV: CNT frozen; countdown resumes after release, total stall = MULDIV_CYCLES-1 + busy cycles.
- RESET mid-MULDIV_BUSY: abort to RUN, no MULDIV_DONE.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs STALL_COUNT[31:0] (cycles with PC_STALL=1) and FLUSH_COUNT[31:0] (cycles with IDEX_FLUSH=1); reset to 0, saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Load x5 in EX, ID reads x5 via rs2 (ID_USE2=1) -> 1 cycle PC_STALL/IFID_STALL/IDEX_FLUSH, next cycle all 0; same with EXE_ADDR=0 -> no stall.
- EXE_MULDIV=1, MULDIV_CYCLES=4 -> PC_STALL high 3 cycles, MULDIV_DONE high on cycle 4, EXMEM_FLUSH high 3 cycles.
- MULDIV with DMEM_BUSYWAIT asserted 2 cycles in the middle -> all stalls 2 cycles, MULDIV_DONE on cycle 6.
- BRANCH_TAKEN with simultaneous load-use hit and IMEM_BUSYWAIT -> IFID_FLUSH=1, IDEX_FLUSH=1, PC_STALL=0, state stays RUN.
- RESET asserted in MULDIV_BUSY with CNT=1 -> next cycle RUN, all outputs 0, no MULDIV_DONE.
- With HAZARD_PERF_CNT_EN: load-use + 4-cycle MULDIV -> STALL_COUNT=4, FLUSH_COUNT=1.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage RV32IM pipeline: load-use, multi-cycle MUL/DIV, taken branches, memory busywait.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_controller #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] ID_ADDR1,
  input  logic [4:0] ID_ADDR2,
  input  logic       ID_USE1,
  input  logic       ID_USE2,
  input  logic [4:0] EXE_ADDR,
  input  logic       EXE_MEMREAD,
  input  logic       EXE_MULDIV,
  input  logic       BRANCH_TAKEN,
  input  logic       IMEM_BUSYWAIT,
  input  logic       DMEM_BUSYWAIT,
  output logic       PC_STALL,
  output logic       IFID_STALL,
  output logic       IDEX_STALL,
  output logic       EXMEM_STALL,
  output logic       MEMWB_STALL,
  output logic       IFID_FLUSH,
  output logic       IDEX_FLUSH,
  output logic       EXMEM_FLUSH,
  output logic       MULDIV_DONE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] STALL_COUNT,
  output logic [31:0] FLUSH_COUNT
`endif
);

  localparam int CW = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = (MULDIV_CYCLES > 1) ? CW'(MULDIV_CYCLES - 2) : '0;
  localparam logic MULTI_CYCLE = (MULDIV_CYCLES > 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_STALL  = 2'd1,
    MULDIV_BUSY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_hit_s;
  logic          muldiv_stall_s;
  logic          muldiv_done_s;
  logic          branch_ok_s;

  assign load_hit_s = EXE_MEMREAD && (EXE_ADDR != 5'd0) &&
                      ((ID_USE1 && (ID_ADDR1 == EXE_ADDR)) ||
                       (ID_USE2 && (ID_ADDR2 == EXE_ADDR)));

  assign muldiv_stall_s = ((state_q == RUN) && EXE_MULDIV && MULTI_CYCLE) ||
                          ((state_q == MULDIV_BUSY) && (cnt_q != '0));

  assign muldiv_done_s = ((state_q == MULDIV_BUSY) && (cnt_q == '0)) ||
                         ((state_q == RUN) && EXE_MULDIV && !MULTI_CYCLE);

  // A branch paired with a MUL/DIV in EX is illegal and is ignored.
  assign branch_ok_s = BRANCH_TAKEN && !EXE_MULDIV && (state_q != MULDIV_BUSY);

  // State and countdown register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; everything freezes while data memory is busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!DMEM_BUSYWAIT) begin
      case (state_q)
        RUN: begin
          if (EXE_MULDIV && MULTI_CYCLE) begin
            state_d = MULDIV_BUSY;
            cnt_d   = CNT_INIT;
          end else if (load_hit_s && !BRANCH_TAKEN && !EXE_MULDIV) begin
            state_d = LOAD_STALL;
          end else begin
            state_d = RUN;
          end
        end
        LOAD_STALL: state_d = RUN;
        MULDIV_BUSY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Prioritised stall/flush outputs.
  always_comb begin
    PC_STALL    = 1'b0;
    IFID_STALL  = 1'b0;
    IDEX_STALL  = 1'b0;
    EXMEM_STALL = 1'b0;
    MEMWB_STALL = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_FLUSH = 1'b0;
    MULDIV_DONE = 1'b0;
    if (RESET) begin
      MULDIV_DONE = 1'b0;
    end else if (DMEM_BUSYWAIT) begin
      PC_STALL    = 1'b1;
      IFID_STALL  = 1'b1;
      IDEX_STALL  = 1'b1;
      EXMEM_STALL = 1'b1;
      MEMWB_STALL = 1'b1;
    end else if (muldiv_stall_s) begin
      PC_STALL    = 1'b1;
      IFID_STALL  = 1'b1;
      IDEX_STALL  = 1'b1;
      EXMEM_FLUSH = 1'b1;
    end else begin
      MULDIV_DONE = muldiv_done_s;
      if (branch_ok_s) begin
        IFID_FLUSH = 1'b1;
        IDEX_FLUSH = 1'b1;
      end else if (load_hit_s && (state_q == RUN) && !EXE_MULDIV) begin
        PC_STALL   = 1'b1;
        IFID_STALL = 1'b1;
        IDEX_FLUSH = 1'b1;
      end else if (IMEM_BUSYWAIT) begin
        PC_STALL   = 1'b1;
        IFID_FLUSH = 1'b1;
      end else begin
        PC_STALL = 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters of stalled-PC cycles and ID/EX bubbles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (PC_STALL && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (IDEX_FLUSH && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign STALL_COUNT = stall_cnt_q;
  assign FLUSH_COUNT = flush_cnt_q;
`endif

endmodule
